// File: rtl/sha_msg_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha_msg_sched_pkg : shared constants and FSM encoding for the SHA-256 message
// scheduler. Revision 1.0
// ----------------------------------------------------------------------------
package sha_msg_sched_pkg;

   localparam int SCHED_DATA_W      = 32;
   localparam int SCHED_ROUNDS      = 64;
   localparam int SCHED_BLOCK_WORDS = 16;
   localparam int AMT_W             = 5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_EXPAND = 2'd2,
      ST_DRAIN  = 2'd3
   } sched_state_e;

   localparam logic [AMT_W-1:0] SIG0_R1_DEF = 5'd7;
   localparam logic [AMT_W-1:0] SIG0_R2_DEF = 5'd18;
   localparam logic [AMT_W-1:0] SIG0_S_DEF  = 5'd3;
   localparam logic [AMT_W-1:0] SIG1_R1_DEF = 5'd17;
   localparam logic [AMT_W-1:0] SIG1_R2_DEF = 5'd19;
   localparam logic [AMT_W-1:0] SIG1_S_DEF  = 5'd10;

endpackage
`default_nettype wire

// File: rtl/sha_msg_sched_sigma.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sched_sigma : combinational rotr ^ rotr ^ shr small-sigma function.
// Revision 1.0
// ----------------------------------------------------------------------------
module sched_sigma
   import sha_msg_sched_pkg::*;
#(
   parameter int DATA_W = SCHED_DATA_W
) (
   input  logic [DATA_W-1:0] x,
   input  logic [AMT_W-1:0]  r1,
   input  logic [AMT_W-1:0]  r2,
   input  logic [AMT_W-1:0]  s,
   output logic [DATA_W-1:0] y
);

   // Left-shift amount is (32 - r) mod 32, so r = 0 ORs x with itself.
   logic [AMT_W-1:0]  w_lsh1;
   logic [AMT_W-1:0]  w_lsh2;
   logic [DATA_W-1:0] w_rot1;
   logic [DATA_W-1:0] w_rot2;

   assign w_lsh1 = -r1;
   assign w_lsh2 = -r2;
   assign w_rot1 = (x >> r1) | (x << w_lsh1);
   assign w_rot2 = (x >> r2) | (x << w_lsh2);
   assign y      = w_rot1 ^ w_rot2 ^ (x >> s);

endmodule
`default_nettype wire

// File: rtl/sha_msg_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha_msg_sched : SHA-256 message-schedule stream W[0..63] from one 16-word
// block. Build macro SHA_MSG_SCHED_FIXED_CONST_EN hard-wires sigma amounts.
// Revision 1.0
// ----------------------------------------------------------------------------
module sha_msg_sched
   import sha_msg_sched_pkg::*;
#(
   parameter int DATA_W      = SCHED_DATA_W,
   parameter int ROUNDS      = SCHED_ROUNDS,
   parameter int BLOCK_WORDS = SCHED_BLOCK_WORDS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in0,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out0,
   output logic              out_last,
   output logic              done,
   input  logic [31:0]       constant_00,
   input  logic [31:0]       constant_01,
   input  logic [31:0]       constant_02,
   input  logic [31:0]       constant_03,
   input  logic [31:0]       constant_04,
   input  logic [31:0]       constant_05
);

   localparam int T_W = $clog2(ROUNDS + 1);

   sched_state_e      state_q, state_d;
   logic [T_W-1:0]    t_q, t_d;
   logic [DATA_W-1:0] win_q [BLOCK_WORDS];
   logic [DATA_W-1:0] out0_q, out0_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              done_q, done_d;

   logic              w_slot_free;
   logic              w_shift;
   logic [DATA_W-1:0] w_new_word;
   logic [DATA_W-1:0] w_expand_word;
   logic [DATA_W-1:0] w_s0;
   logic [DATA_W-1:0] w_s1;
   logic [AMT_W-1:0]  w_s0_r1, w_s0_r2, w_s0_s;
   logic [AMT_W-1:0]  w_s1_r1, w_s1_r2, w_s1_s;

`ifdef SHA_MSG_SCHED_FIXED_CONST_EN
   logic w_unused_const;
   assign w_unused_const = ^{constant_00, constant_01, constant_02,
                             constant_03, constant_04, constant_05};
   assign w_s0_r1 = SIG0_R1_DEF;
   assign w_s0_r2 = SIG0_R2_DEF;
   assign w_s0_s  = SIG0_S_DEF;
   assign w_s1_r1 = SIG1_R1_DEF;
   assign w_s1_r2 = SIG1_R2_DEF;
   assign w_s1_s  = SIG1_S_DEF;
`else
   logic [AMT_W-1:0] amt_q [6];
   logic             w_unused_const_hi;
   assign w_unused_const_hi = ^{constant_00[31:AMT_W], constant_01[31:AMT_W],
                                constant_02[31:AMT_W], constant_03[31:AMT_W],
                                constant_04[31:AMT_W], constant_05[31:AMT_W]};

   // Amounts are frozen at block start so the ports may change mid-block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 6; i++) amt_q[i] <= '0;
      end else if (state_q == ST_IDLE && run) begin
         amt_q[0] <= constant_00[AMT_W-1:0];
         amt_q[1] <= constant_01[AMT_W-1:0];
         amt_q[2] <= constant_02[AMT_W-1:0];
         amt_q[3] <= constant_03[AMT_W-1:0];
         amt_q[4] <= constant_04[AMT_W-1:0];
         amt_q[5] <= constant_05[AMT_W-1:0];
      end
   end

   assign w_s0_r1 = amt_q[0];
   assign w_s0_r2 = amt_q[1];
   assign w_s0_s  = amt_q[2];
   assign w_s1_r1 = amt_q[3];
   assign w_s1_r2 = amt_q[4];
   assign w_s1_s  = amt_q[5];
`endif

   sched_sigma #(.DATA_W(DATA_W)) u_sigma0 (
      .x  (win_q[1]),
      .r1 (w_s0_r1),
      .r2 (w_s0_r2),
      .s  (w_s0_s),
      .y  (w_s0)
   );

   sched_sigma #(.DATA_W(DATA_W)) u_sigma1 (
      .x  (win_q[BLOCK_WORDS-2]),
      .r1 (w_s1_r1),
      .r2 (w_s1_r2),
      .s  (w_s1_s),
      .y  (w_s1)
   );

   // win_q[0] is W[t-16], win_q[15] is W[t-1].
   assign w_expand_word = w_s1 + win_q[BLOCK_WORDS-7] + w_s0 + win_q[0];
   assign w_slot_free   = !out_valid_q || out_ready;

   always_comb begin
      state_d     = state_q;
      t_d         = t_q;
      out0_d      = out0_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      in_ready    = 1'b0;
      w_shift     = 1'b0;
      w_new_word  = w_expand_word;

      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_LOAD;
               t_d     = '0;
            end
         end
         ST_LOAD: begin
            in_ready = w_slot_free;
            if (in_valid && w_slot_free) begin
               w_new_word = in0;
               w_shift    = 1'b1;
               t_d        = t_q + T_W'(1);
               if (t_q == T_W'(BLOCK_WORDS - 1)) state_d = ST_EXPAND;
            end
         end
         ST_EXPAND: begin
            if (w_slot_free) begin
               w_shift = 1'b1;
               t_d     = t_q + T_W'(1);
               if (t_q == T_W'(ROUNDS - 1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (out_valid_q && out_ready) begin
               state_d = ST_IDLE;
               t_d     = '0;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The output slot either takes the new word or empties after a handshake.
      if (w_slot_free) begin
         out_valid_d = w_shift;
         out_last_d  = w_shift && (t_q == T_W'(ROUNDS - 1));
         if (w_shift) out0_d = w_new_word;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         t_q         <= '0;
         out0_q      <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         t_q         <= t_d;
         out0_q      <= out0_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BLOCK_WORDS; i++) win_q[i] <= '0;
      end else if (w_shift) begin
         for (int i = 0; i < BLOCK_WORDS - 1; i++) win_q[i] <= win_q[i+1];
         win_q[BLOCK_WORDS-1] <= w_new_word;
      end
   end

   assign out0      = out0_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign done      = done_q;

endmodule
`default_nettype wire
